// File: rtl/l23_temac2fifo_v3.sv
// TEMAC receive stream to L23 FIFO bridge: zero-latency pass-through that flags
// damaged, runt and oversize frames on their last beat and keeps saturating frame statistics.
module l23_temac2fifo_v3 #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 14,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              L23_clk,
  input  logic              L23_rst_n,
  input  logic [DATA_W-1:0] L23i_tdata,
  input  logic              L23i_tlast,
  input  logic              L23i_tuser,
  input  logic              L23i_tvalid,
  output logic              L23i_tready,
  output logic [DATA_W-1:0] L23o_tdata,
  output logic              L23o_tlast,
  output logic              L23o_tuser,
  output logic              L23o_tvalid,
  input  logic              L23o_tready,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_bad,
  output logic [CNT_W-1:0]  beats_dropped
);

  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StPass, StBad} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d, n;
  logic [CNT_W-1:0] ok_q, bad_q, drop_q;
  logic             acc, lost, over, runt, eop;

  assign L23i_tready = L23o_tready;
  assign L23o_tdata  = L23i_tdata;
  assign L23o_tlast  = L23i_tlast;
  assign L23o_tvalid = L23i_tvalid;

  assign acc  = L23i_tvalid & L23o_tready;
  assign lost = L23i_tvalid & ~L23o_tready;
  assign eop  = acc & L23i_tlast;

  // Beat count including the current beat, pinned at all-ones on very long frames.
  assign n    = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
  assign over = (n > MaxLen);
  assign runt = L23i_tlast & (n < MinLen);

  assign L23o_tuser = L23i_tuser | (eop & ((state_q == StBad) | over | runt));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (acc) begin
      beat_cnt_d = L23i_tlast ? '0 : n;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lost) begin
          state_d = StBad;
        end else if (acc && !L23i_tlast) begin
          state_d = over ? StBad : StPass;
        end
      end
      StPass: begin
        if (lost) begin
          state_d = StBad;
        end else if (eop) begin
          state_d = StIdle;
        end else if (acc && over) begin
          state_d = StBad;
        end
      end
      StBad: begin
        // A lost tlast keeps us here, merging into the next frame.
        if (eop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge L23_clk or negedge L23_rst_n) begin
    if (!L23_rst_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge L23_clk or negedge L23_rst_n) begin
    if (!L23_rst_n) begin
      ok_q   <= '0;
      bad_q  <= '0;
      drop_q <= '0;
    end else if (clr_stats) begin
      ok_q   <= '0;
      bad_q  <= '0;
      drop_q <= '0;
    end else begin
      if (eop && L23o_tuser && !(&bad_q)) begin
        bad_q <= bad_q + 1'b1;
      end
      if (eop && !L23o_tuser && !(&ok_q)) begin
        ok_q <= ok_q + 1'b1;
      end
      if (lost && !(&drop_q)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign frames_ok     = ok_q;
  assign frames_bad    = bad_q;
  assign beats_dropped = drop_q;

endmodule
